// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_if
//  Description : Fetch-address handshake and redirect bundle between pc_gen
//                and the instruction-fetch side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_gen_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic [XLEN-1:0]  pc_o;
    logic             pc_valid;
    logic             pc_ready;
    logic             jmp_en;
    logic             jmpb_en;
    logic             jmpr_en;
    logic [XLEN-1:0]  offset;
    logic             halt;
    logic             trap_en;
    logic [XLEN-1:0]  trap_vec;
    logic             misalign;
    logic [XLEN-1:0]  fault_addr;
    logic             halted;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        output pc_o, pc_valid, misalign, fault_addr, halted, fetch_cnt,
        input  pc_ready, jmp_en, jmpb_en, jmpr_en, offset, halt, trap_en, trap_vec
    );

    modport slave (
        input  pc_o, pc_valid, misalign, fault_addr, halted, fetch_cnt,
        output pc_ready, jmp_en, jmpb_en, jmpr_en, offset, halt, trap_en, trap_vec
    );
endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Program-counter generator for the fetch stage with
//                sequential/jal/branch/jalr/trap redirects, misalignment
//                fault, halt state and a fetch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = 32'h8000_0000,
    parameter int              ILEN_BYTES = 4,
    parameter int              OFF_SHIFT  = 1,
    parameter int              CNT_W      = 64
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pc_gen_if.master    bus
);

    localparam logic [1:0] c_ST_RST   = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FAULT = 2'd2;
    localparam logic [1:0] c_ST_HALT  = 2'd3;

    localparam logic [XLEN-1:0]  c_ALIGN_MASK = XLEN'(ILEN_BYTES - 1);
    localparam logic [XLEN-1:0]  c_ILEN       = XLEN'(ILEN_BYTES);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    logic [1:0]       r_state;
    logic [XLEN-1:0]  r_pc;
    logic             r_valid;
    logic             r_misalign;
    logic [XLEN-1:0]  r_fault_addr;
    logic             r_halted;
    logic [CNT_W-1:0] r_cnt;

    logic             w_fire;
    logic             w_redirect;
    logic [XLEN-1:0]  w_rel_tgt;
    logic [XLEN-1:0]  w_jalr_tgt;
    logic [XLEN-1:0]  w_tgt;
    logic             w_tgt_misaligned;
    logic [XLEN-1:0]  w_trap_pc;

    // r_valid is only ever set in RUN, so it doubles as the state qualifier
    assign w_fire           = r_valid & bus.pc_ready;
    assign w_redirect       = bus.jmpr_en | bus.jmp_en | bus.jmpb_en;
    assign w_rel_tgt        = r_pc + (bus.offset << OFF_SHIFT);
    assign w_jalr_tgt       = {bus.offset[XLEN-1:1], 1'b0};
    assign w_tgt            = bus.jmpr_en ? w_jalr_tgt : w_rel_tgt;
    assign w_tgt_misaligned = |(w_tgt & c_ALIGN_MASK);
    assign w_trap_pc        = bus.trap_vec & ~c_ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_RST;
            r_pc         <= RESET_VEC;
            r_valid      <= 1'b0;
            r_misalign   <= 1'b0;
            r_fault_addr <= '0;
            r_halted     <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_fire) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            case (r_state)
                c_ST_RST: begin
                    r_state <= c_ST_RUN;
                    r_valid <= 1'b1;
                end
                c_ST_RUN, c_ST_FAULT: begin
                    if (bus.trap_en) begin
                        r_pc       <= w_trap_pc;
                        r_state    <= c_ST_RUN;
                        r_valid    <= 1'b1;
                        r_misalign <= 1'b0;
                    end else if (w_fire) begin
                        if (bus.halt) begin
                            r_state  <= c_ST_HALT;
                            r_halted <= 1'b1;
                            r_valid  <= 1'b0;
                        end else if (w_redirect && w_tgt_misaligned) begin
                            // pc stays on the instruction that produced the bad target
                            r_state      <= c_ST_FAULT;
                            r_misalign   <= 1'b1;
                            r_fault_addr <= w_tgt;
                            r_valid      <= 1'b0;
                        end else if (w_redirect) begin
                            r_pc <= w_tgt;
                        end else begin
                            r_pc <= r_pc + c_ILEN;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.pc_o       = r_pc;
    assign bus.pc_valid   = r_valid;
    assign bus.misalign   = r_misalign;
    assign bus.fault_addr = r_fault_addr;
    assign bus.halted     = r_halted;
    assign bus.fetch_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Self-checking bench for pc_gen: directed fetch scenarios and
//                randomized traffic against a behavioural model scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] c_RESET_VEC = 32'h8000_0000;

    localparam int c_M_RST   = 0;
    localparam int c_M_RUN   = 1;
    localparam int c_M_FAULT = 2;
    localparam int c_M_HALT  = 3;

    typedef struct {
        logic [31:0] pc;
        bit          valid;
        bit          mis;
        logic [31:0] fa;
        bit          halted;
        logic [63:0] cnt;
    } exp_t;

    logic clk;
    logic rst;

    pc_gen_if #(.XLEN(32), .CNT_W(64)) bus ();

    pc_gen #(
        .XLEN       (32),
        .RESET_VEC  (c_RESET_VEC),
        .ILEN_BYTES (4),
        .OFF_SHIFT  (1),
        .CNT_W      (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    // model state, described in terms of the architectural behaviour
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_fa;
    bit          m_mis;
    bit          m_halted;
    logic [63:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit rdy, input bit j, input bit jb, input bit jr,
                        input bit h, input bit t, input logic [31:0] off, input logic [31:0] tv);
        exp_t        e;
        logic [31:0] tgt;
        rst          = r;
        bus.pc_ready = rdy;
        bus.jmp_en   = j;
        bus.jmpb_en  = jb;
        bus.jmpr_en  = jr;
        bus.halt     = h;
        bus.trap_en  = t;
        bus.offset   = off;
        bus.trap_vec = tv;
        if (r) begin
            m_state = c_M_RST; m_pc = c_RESET_VEC; m_fa = 0;
            m_mis = 0; m_halted = 0; m_cnt = 0;
        end else if (m_state == c_M_RST) begin
            m_state = c_M_RUN;
        end else if ((m_state == c_M_RUN || m_state == c_M_FAULT) && t) begin
            if (m_state == c_M_RUN && rdy) m_cnt = m_cnt + 1;
            m_pc    = tv - (tv % 4);
            m_state = c_M_RUN;
            m_mis   = 0;
        end else if (m_state == c_M_RUN && rdy) begin
            m_cnt = m_cnt + 1;
            if (h) begin
                m_state = c_M_HALT; m_halted = 1;
            end else if (jr || j || jb) begin
                tgt = jr ? off - (off % 2) : m_pc + off * 2;
                if (tgt % 4 != 0) begin
                    m_state = c_M_FAULT; m_mis = 1; m_fa = tgt;
                end else begin
                    m_pc = tgt;
                end
            end else begin
                m_pc = m_pc + 4;
            end
        end
        e.pc = m_pc; e.valid = (m_state == c_M_RUN); e.mis = m_mis;
        e.fa = m_fa; e.halted = m_halted; e.cnt = m_cnt;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // scoreboard monitor: compares every post-edge DUT snapshot with the queued expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_pc_o",      bus.pc_o,      e.pc);
                chk("sb_pc_valid",  bus.pc_valid,  e.valid);
                chk("sb_misalign",  bus.misalign,  e.mis);
                chk("sb_halted",    bus.halted,    e.halted);
                chk("sb_fetch_cnt", bus.fetch_cnt, e.cnt);
                if (e.mis) chk("sb_fault_addr", bus.fault_addr, e.fa);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit          r, rdy, j, jb, jr, h, t;
        logic [31:0] off;
        rst = 1'b1;
        bus.pc_ready = 0; bus.jmp_en = 0; bus.jmpb_en = 0; bus.jmpr_en = 0;
        bus.halt = 0; bus.trap_en = 0; bus.offset = 0; bus.trap_vec = 0;
        m_state = c_M_RST; m_pc = c_RESET_VEC; m_fa = 0; m_mis = 0; m_halted = 0; m_cnt = 0;
        @(negedge clk);

        // reset state, bubble, then four sequential fires
        step(1'b1, 1'b1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("rst_pc", bus.pc_o, c_RESET_VEC);
        chk("rst_valid", bus.pc_valid, 1'b0);
        chk("rst_cnt", bus.fetch_cnt, 64'd0);
        chk("rst_misalign", bus.misalign, 1'b0);
        idle(1'b1);
        chk("first_valid_pc", bus.pc_o, c_RESET_VEC);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("seq_pc", bus.pc_o, 32'h8000_0010);
        chk("seq_cnt", bus.fetch_cnt, 64'd4);

        // jal held through a 3-cycle stall
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 32'h10, 32'h0);
        chk("stall_pc", bus.pc_o, 32'h8000_0010);
        step(0, 1, 1, 0, 0, 0, 0, 32'h10, 32'h0);
        chk("jal_pc", bus.pc_o, 32'h8000_0030);

        // jalr wins over jal, bit 0 cleared
        step(0, 1, 1, 0, 1, 0, 0, 32'h8000_0101, 32'h0);
        chk("jalr_pc", bus.pc_o, 32'h8000_0100);

        // misaligned branch then trap recovery
        step(0, 1, 0, 1, 0, 0, 0, 32'h1, 32'h0);
        chk("mis_flag", bus.misalign, 1'b1);
        chk("mis_addr", bus.fault_addr, 32'h8000_0102);
        chk("mis_valid", bus.pc_valid, 1'b0);
        chk("mis_pc", bus.pc_o, 32'h8000_0100);
        step(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h8000_0203);
        chk("trap_pc", bus.pc_o, 32'h8000_0200);
        chk("trap_mis", bus.misalign, 1'b0);
        chk("trap_valid", bus.pc_valid, 1'b1);

        // halt at 8000_0040, trap ignored, reset recovers
        step(0, 1, 0, 0, 1, 0, 0, 32'h8000_0040, 32'h0);
        step(0, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
        chk("halt_flag", bus.halted, 1'b1);
        chk("halt_valid", bus.pc_valid, 1'b0);
        chk("halt_pc", bus.pc_o, 32'h8000_0040);
        step(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h1000_0000);
        chk("halt_trap_pc", bus.pc_o, 32'h8000_0040);
        chk("halt_trap_flag", bus.halted, 1'b1);
        step(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("halt_rst_pc", bus.pc_o, c_RESET_VEC);
        chk("halt_rst_flag", bus.halted, 1'b0);

        // sequential wrap at the top of the address space
        idle(1'b1);
        step(0, 1, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0);
        chk("wrap_pre_pc", bus.pc_o, 32'hFFFF_FFFC);
        idle(1'b1);
        chk("wrap_pc", bus.pc_o, 32'h0000_0000);
        chk("wrap_mis", bus.misalign, 1'b0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r   = (m_state == c_M_HALT) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            jr  = ($urandom_range(0, 7) == 0);
            j   = ($urandom_range(0, 7) == 0);
            jb  = ($urandom_range(0, 7) == 0);
            h   = ($urandom_range(0, 99) == 0);
            t   = ($urandom_range(0, 29) == 0);
            off = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFE);
            if ($urandom_range(0, 7) == 0) off = off | 32'h1;
            step(r, rdy, j, jb, jr, h, t, off, $urandom);
        end

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        chk("sb_drain", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the NPC fetch stage. It holds the current fetch address and presents it to instruction fetch through a valid/ready handshake. It computes the next address from sequential increment, jal, branch, jalr or trap redirects, and detects misaligned targets. Halt and fault states stop fetch cleanly, and a fetch counter supports performance checks.

## Interface

- XLEN, 32: address / offset width
- RESET_VEC, 32'h8000_0000: PC value loaded by reset (XLEN bits)
- ILEN_BYTES, 4: sequential increment and required target alignment (power of two, ≥2)
- OFF_SHIFT, 1: left shift applied to `offset` for jal/branch targets
- CNT_W, 64: fetch counter width

- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- pc_o  out  XLEN  current fetch address
- pc_valid  out  1  pc_o is a valid fetch request
- pc_ready  in  1  fetch consumer accepts pc_o; a fire is pc_valid & pc_ready
- jmp_en  in  1  jal for the presented PC
- jmpb_en  in  1  taken branch for the presented PC
- jmpr_en  in  1  jalr for the presented PC
- offset  in  XLEN  immediate for jal/branch, absolute target for jalr
- halt  in  1  stop fetch after the presented PC (ebreak)
- trap_en  in  1  asynchronous-to-flow redirect to trap_vec
- trap_vec  in  XLEN  trap target
- misalign  out  1  fault state, misaligned target detected
- fault_addr  out  XLEN  offending target, valid while misalign=1
- halted  out  1  HALT state
- fetch_cnt  out  CNT_W  number of fires since reset

## Operation

- States: RST, RUN, FAULT, HALT.
- Reset (rst=1 at posedge): state=RST, pc_o=RESET_VEC, pc_valid=0, misalign=0, fault_addr=0, halted=0, fetch_cnt=0.
- RST to RUN unconditionally on the next cycle. pc_valid is asserted only in RUN.
- Redirect inputs jmp_en, jmpb_en, jmpr_en and halt refer to the PC currently on pc_o. They are acted on only at a fire and ignored otherwise. No buffering is done: the producer holds them with pc_o until fire.
- Target computation, all modulo 2^XLEN, with carries out discarded:
  - jal and branch target = pc_o + (offset << OFF_SHIFT); bits shifted out are lost.
  - jalr target = offset with bit 0 cleared.
  - sequential target = pc_o + ILEN_BYTES; wraps from all-ones region to 0 silently.
- Priority at a fire in RUN: trap_en > halt > jmpr_en > jmp_en > jmpb_en > sequential.
- Misalignment: if the selected jal, branch or jalr target has any of the low log2(ILEN_BYTES) bits set:
  - pc_o is unchanged;
  - state goes to FAULT with misalign=1 and fault_addr=target;
  - pc_valid drops.
- halt at fire: state goes to HALT, halted=1, and pc_o holds the halting PC. HALT is left only by rst.
- trap_en in RUN or FAULT takes effect regardless of pc_ready:
  - pc_o = trap_vec with the low log2(ILEN_BYTES) bits forced to 0;
  - state goes to RUN and misalign clears;
  - fetch_cnt increments only if this cycle was also a fire.
- trap_en is ignored in RST and HALT.
- fetch_cnt increments by 1 on every fire, including a fire that leads to FAULT or HALT, and wraps at 2^CNT_W.
- Inputs other than trap_en and rst are ignored in FAULT and HALT.

## Timing

- One bubble after reset: pc_valid rises in the 2nd cycle after rst deasserts, with pc_o=RESET_VEC.
- Redirect latency is 1 cycle: the new target is on pc_o the cycle after the fire (or after trap_en).
- With pc_ready held high and no redirects, pc_o advances by ILEN_BYTES every cycle.
- With pc_ready=0, pc_o and all outputs hold.
- rst mid-operation, in any state including FAULT or HALT, overrides everything at that posedge.
- misalign and halted are registered and assert the cycle after the causing fire.

## Test plan

- Reset then pc_ready=1 for 4 cycles:
  - pc_o follows 8000_0000, 8000_0004, 8000_0008, 8000_000C;
  - pc_valid=0 in the first post-reset cycle;
  - fetch_cnt=4.
- At pc_o=8000_0010, jmp_en=1 and offset=0x10 (so 0x20 after shift), with pc_ready=0 for 3 cycles then 1:
  - pc_o holds 8000_0010 during the stall;
  - pc_o is 8000_0030 the cycle after the fire.
- jmpr_en=1, jmp_en=1 and offset=8000_0101 in the same fire: pc_o becomes 8000_0100, showing jalr priority and bit 0 cleared.
- Misaligned branch, jmpb_en=1 and offset=1 (shifted +2):
  - misalign=1, fault_addr=pc+2, pc_valid=0, pc_o unchanged;
  - then trap_en=1 with trap_vec=8000_0203: pc_o=8000_0200, state RUN, misalign=0.
- halt at a fire at pc_o=8000_0040:
  - halted=1, pc_valid=0, pc_o stays 8000_0040;
  - trap_en is then ignored;
  - rst returns pc_o to 8000_0000.
- XLEN=32 with pc_o=FFFF_FFFC and a sequential fire: pc_o wraps to 0000_0000 with no fault.
